// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one cache-line memory port; grant is held until the memory acks.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i
);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  state_e state_q;
  logic   last_grant_q;
  logic   tie_pick1;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_pick1 = ~last_grant_q;
`else
  // last_grant is kept up to date but does not steer ties in fixed-priority mode.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
  assign tie_pick1         = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (m0_enable_i && (!m1_enable_i || !tie_pick1)) begin
            state_q      <= StGrant0;
            last_grant_q <= 1'b0;
          end else if (m1_enable_i) begin
            state_q      <= StGrant1;
            last_grant_q <= 1'b1;
          end
        end
        // An abandoned request releases the port; its late ack then lands in idle.
        StGrant0: if (mem_ack_i || !m0_enable_i) state_q <= StIdle;
        StGrant1: if (mem_ack_i || !m1_enable_i) state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state_q)
      StGrant0: begin
        mem_enable_o = m0_enable_i;
        mem_write_o  = m0_write_i;
        mem_addr_o   = m0_addr_i;
        mem_data_o   = m0_data_i;
      end
      StGrant1: begin
        mem_enable_o = m1_enable_i;
        mem_write_o  = m1_write_i;
        mem_addr_o   = m1_addr_i;
        mem_data_o   = m1_data_i;
      end
      default: ;
    endcase
  end

  assign m0_ack_o  = mem_ack_i & (state_q == StGrant0);
  assign m1_ack_o  = mem_ack_i & (state_q == StGrant1);
  assign m0_data_o = mem_data_i;
  assign m1_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; tie expectations follow ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;
  localparam int unsigned DW = 256;
  localparam int unsigned AW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [DW-1:0] m0_data_i, m1_data_i;
  logic          m0_ack_o, m1_ack_o;
  logic [DW-1:0] m0_data_o, m1_data_o;
  logic          mem_enable_o, mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_data_i;

  int checks = 0;
  int errors = 0;

  localparam logic [DW-1:0] Pat_a5 = {8{32'hA5A5_A5A5}};
  localparam logic [DW-1:0] Wdata0 = {8{32'h1234_5678}};
  localparam logic [DW-1:0] Wdata1 = {8{32'hCAFE_F00D}};

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .m0_enable_i  (m0_enable_i),
    .m0_write_i   (m0_write_i),
    .m0_addr_i    (m0_addr_i),
    .m0_data_i    (m0_data_i),
    .m0_ack_o     (m0_ack_o),
    .m0_data_o    (m0_data_o),
    .m1_enable_i  (m1_enable_i),
    .m1_write_i   (m1_write_i),
    .m1_addr_i    (m1_addr_i),
    .m1_data_i    (m1_data_i),
    .m1_ack_o     (m1_ack_o),
    .m1_data_o    (m1_data_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_outputs(input string tag);
    #1;
    check({tag, " mem_enable"}, DW'(mem_enable_o), '0);
    check({tag, " mem_addr"}, DW'(mem_addr_o), '0);
    check({tag, " m0_ack"}, DW'(m0_ack_o), '0);
    check({tag, " m1_ack"}, DW'(m1_ack_o), '0);
  endtask

  initial begin
    int exp_port;
    rst_i = 1'b0;
    m0_enable_i = 1'b0; m0_write_i = 1'b0; m0_addr_i = '0; m0_data_i = '0;
    m1_enable_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = '0; m1_data_i = '0;
    mem_ack_i = 1'b0; mem_data_i = '0;

    // Reset state
    #2;
    check("rst mem_enable", DW'(mem_enable_o), '0);
    check("rst mem_write", DW'(mem_write_o), '0);
    check("rst mem_data", mem_data_o, '0);
    step(); step();
    rst_i = 1'b1;
    idle_outputs("post-rst");

    // Single read, port 0, memory acks 10 cycles after enable rises
    m0_enable_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h0000_0400;
    #1 check("rd0 latency", DW'(mem_enable_o), '0);
    step();
    check("rd0 enable", DW'(mem_enable_o), DW'(1));
    check("rd0 addr", DW'(mem_addr_o), DW'(32'h400));
    check("rd0 write", DW'(mem_write_o), '0);
    for (int i = 0; i < 10; i++) step();
    mem_ack_i = 1'b1; mem_data_i = Pat_a5;
    #1;
    check("rd0 m0_ack", DW'(m0_ack_o), DW'(1));
    check("rd0 m1_ack", DW'(m1_ack_o), '0);
    check("rd0 data", m0_data_o, Pat_a5);
    check("rd0 m1 data", m1_data_o, Pat_a5);
    step();
    mem_ack_i = 1'b0; m0_enable_i = 1'b0;
    idle_outputs("rd0 release");

    // Reset mid-transaction
    m0_enable_i = 1'b1; m0_addr_i = 32'h0000_0400;
    step();
    check("mid grant", DW'(mem_enable_o), DW'(1));
    step();
    rst_i = 1'b0;
    idle_outputs("mid async");
    m0_write_i = 1'b1; m0_data_i = Wdata0;
    m1_enable_i = 1'b1; m1_write_i = 1'b0; m1_addr_i = 32'h0000_0800; m1_data_i = Wdata1;
    step();
    idle_outputs("mid held");
    rst_i = 1'b1;
    idle_outputs("mid release");

    // Both held across 4 acks: round-robin alternates, fixed priority starves port 1
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_port = k % 2;
`else
      exp_port = 0;
`endif
      step();
      check($sformatf("tie%0d enable", k), DW'(mem_enable_o), DW'(1));
      check($sformatf("tie%0d addr", k), DW'(mem_addr_o),
            (exp_port == 0) ? DW'(32'h400) : DW'(32'h800));
      check($sformatf("tie%0d write", k), DW'(mem_write_o), (exp_port == 0) ? DW'(1) : '0);
      check($sformatf("tie%0d wdata", k), mem_data_o, (exp_port == 0) ? Wdata0 : Wdata1);
      step();
      mem_ack_i = 1'b1;
      #1;
      check($sformatf("tie%0d m0_ack", k), DW'(m0_ack_o), (exp_port == 0) ? DW'(1) : '0);
      check($sformatf("tie%0d m1_ack", k), DW'(m1_ack_o), (exp_port == 1) ? DW'(1) : '0);
      step();
      mem_ack_i = 1'b0;
      idle_outputs($sformatf("tie%0d gap", k));
    end
    m0_enable_i = 1'b0;
    step();
    check("m1 after m0 drop addr", DW'(mem_addr_o), DW'(32'h800));
    check("m1 after m0 drop en", DW'(mem_enable_o), DW'(1));
    mem_ack_i = 1'b1;
    #1 check("m1 after m0 drop ack", DW'(m1_ack_o), DW'(1));
    step();
    mem_ack_i = 1'b0; m1_enable_i = 1'b0;
    idle_outputs("tie end");

    // Writeback then refill from port 0
    m0_enable_i = 1'b1; m0_write_i = 1'b1; m0_addr_i = 32'h0000_1000;
    step();
    check("wb write", DW'(mem_write_o), DW'(1));
    check("wb addr", DW'(mem_addr_o), DW'(32'h1000));
    step();
    mem_ack_i = 1'b1;
    #1 check("wb ack", DW'(m0_ack_o), DW'(1));
    step();
    mem_ack_i = 1'b0; m0_write_i = 1'b0; m0_addr_i = 32'h0000_2000;
    idle_outputs("wb gap");
    step();
    check("refill enable", DW'(mem_enable_o), DW'(1));
    check("refill write", DW'(mem_write_o), '0);
    check("refill addr", DW'(mem_addr_o), DW'(32'h2000));
    mem_ack_i = 1'b1;
    #1 check("refill ack", DW'(m0_ack_o), DW'(1));
    step();
    mem_ack_i = 1'b0; m0_enable_i = 1'b0;
    idle_outputs("refill end");

    // Abandoned request on port 1: release at grant+4, late ack dropped
    m1_enable_i = 1'b1; m1_write_i = 1'b0; m1_addr_i = 32'h0000_0800;
    step();
    check("ab grant addr", DW'(mem_addr_o), DW'(32'h800));
    step(); step(); step();
    m1_enable_i = 1'b0;
    #1;
    check("ab drop enable", DW'(mem_enable_o), '0);
    check("ab still granted", DW'(mem_addr_o), DW'(32'h800));
    step();
    check("ab idle at g+4", DW'(mem_addr_o), '0);
    for (int i = 0; i < 6; i++) step();
    mem_ack_i = 1'b1;
    idle_outputs("ab late ack");
    step();
    mem_ack_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single 256-bit data-memory port between two cache-line requesters: port 0 is the data cache, port 1 is the instruction cache or a second data cache.
- Each requester uses the same enable/write/address/data/ack protocol as the memory.
- The arbiter grants one requester at a time and holds that grant until the memory acknowledges.
- It sits between the cache controllers and the data memory.

## Interface
Parameters:
- DATA_W, 256, cache-line width in bits
- ADDR_W, 32, byte-address width

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; asynchronous, active-low (0 = reset)
- m0_enable_i  in  1  port 0 request; held high until m0_ack_o
- m0_write_i  in  1  port 0: 1 = write line, 0 = read line
- m0_addr_i  in  ADDR_W  port 0 line address (bits [4:0] are 0)
- m0_data_i  in  DATA_W  port 0 write data
- m0_ack_o  out  1  port 0 acknowledge
- m0_data_o  out  DATA_W  port 0 read data
- m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_ack_o, m1_data_o: same directions, widths and meaning as port 0, for port 1
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  memory write
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  DATA_W  memory write data
- mem_ack_i  in  1  memory acknowledge; one-cycle pulse
- mem_data_i  in  DATA_W  memory read data

## Operation
- States:
  - IDLE: no grant.
  - GRANT0: port 0 owns memory.
  - GRANT1: port 1 owns memory.
- IDLE transitions:
  - Only m0 requesting → GRANT0.
  - Only m1 requesting → GRANT1.
  - Neither requesting → IDLE.
  - Both requesting → decided by policy (see Configuration).
- GRANTn transitions:
  - mem_ack_i=1 → IDLE.
  - mn_enable_i=0 before ack (abandoned request) → IDLE. The late mem_ack_i is then not forwarded.
  - Otherwise stay in GRANTn.
- Memory-side outputs:
  - In GRANTn: mem_enable_o, mem_write_o, mem_addr_o and mem_data_o combinationally follow port n's inputs.
  - In IDLE: all four are 0.
- Acknowledge routing:
  - mn_ack_o = mem_ack_i & (state==GRANTn).
  - mem_ack_i in IDLE is ignored.
- Read data: m0_data_o and m1_data_o both equal mem_data_i at all times. The requester qualifies the data with its own ack.
- last_grant register (1 bit):
  - Updated to n on every entry into GRANTn.
  - Reset value is 1, so port 0 wins the first tie.
- Reset, including mid-transaction:
  - State goes to IDLE and last_grant to 1.
  - All mem_* outputs and both ack outputs are 0 during reset and in the first cycle after release.
  - An outstanding memory transaction is not cancelled.
  - A mem_ack_i arriving after reset is dropped.

## Timing
- Request latency:
  - A request first high in cycle t while IDLE is sampled at the edge ending t.
  - mem_enable_o is high in cycle t+1.
- Acknowledge: mem_ack_i in cycle a gives mn_ack_o in cycle a (combinational, zero latency).
- Release:
  - State is IDLE in cycle a+1, with mem_enable_o=0 for that cycle.
  - The next grant drives memory no earlier than cycle a+2.
  - This guarantees the memory sees one idle cycle between transactions.
- Back-to-back writeback followed by refill from the same port: the requester keeps its enable high after ack. It is re-arbitrated in the a+1 IDLE cycle and may lose to the other port under round-robin.
- Throughput: one line transaction per (memory latency + 2) cycles at most.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - A tie in IDLE grants the port ≠ last_grant.
  - No port waits more than one transaction behind the other.
- ARB_ROUND_ROBIN_EN undefined:
  - A tie always grants port 0 (fixed priority).
  - last_grant is still maintained but has no effect.

## Test plan
- Single read, port 0:
  - Stimulus: m0 read at 0x0000_0400; memory acks 10 cycles after mem_enable_o rises, with mem_data_i=0xA5…A5.
  - Required: m0_ack_o pulses in the same cycle; m0 receives 0xA5…A5; m1_ack_o stays 0; mem_enable_o=0 in the following cycle.
- Simultaneous requests, ARB_ROUND_ROBIN_EN defined, m0 writing to 0x400 and m1 reading from 0x800:
  - Port 0 is granted first and port 1 second.
  - With both held continuously, grants alternate 0,1,0,1 across 4 acks.
- Simultaneous requests, ARB_ROUND_ROBIN_EN undefined, both held: m0 is granted every time and m1 is starved until m0 drops its enable.
- Writeback then refill:
  - Stimulus: m0 write to 0x1000 then, with enable held, read from 0x2000; m1 is idle.
  - Required: two grants to m0 with exactly one IDLE cycle between them; mem_write_o goes 1 then 0.
- Abandoned request:
  - Stimulus: m1 granted, m1_enable_i drops at grant+3, then mem_ack_i arrives at grant+10.
  - Required: state returns to IDLE at grant+4; the ack is not forwarded to either port.
- Reset mid-transaction:
  - Stimulus: rst_i=0 while GRANT0.
  - Required: mem_enable_o=0 immediately (asynchronously); after release a tie grants port 0.
